// File: rtl/rdoq_rate_pkg.sv
// Shared definitions for the RDOQ sign-bit rate-estimation arbiter.
//   IEP_RATE : Q15 cost of one equiprobable bin (1.0 bit)
//   COST_MAX : saturated cost pattern; consumers slice it to their cost width (<= 64)
//   arb_state_t : arbiter sequencing states
//   id_width() : lane-index width that stays >= 1 for degenerate lane counts
package rdoq_rate_pkg;

  localparam int unsigned IEP_RATE = 32768;
  localparam logic [63:0] COST_MAX = '1;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    RESP
  } arb_state_t;

  function automatic int id_width(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/rate_est_arbiter_rr_pick.sv
// Round-robin one-hot selector (purely combinational).
//   req    : request vector
//   ptr    : highest-priority lane index
//   onehot : one-hot winner (all zero when nothing requests)
//   id     : winner index
//   any    : at least one lane requests
// Lanes at or above ptr are tried first; if none of them request, the search
// wraps to the lowest requesting lane overall.
module rr_pick
  import rdoq_rate_pkg::*;
#(
  parameter int N    = 4,
  parameter int ID_W = id_width(N)
) (
  input  logic [N-1:0]    req,
  input  logic [ID_W-1:0] ptr,
  output logic [N-1:0]    onehot,
  output logic [ID_W-1:0] id,
  output logic            any
);

  logic [N-1:0] mask;
  logic [N-1:0] masked;
  logic [N-1:0] sel;

  genvar gi;
  generate
    for (gi = 0; gi < N; gi++) begin : g_mask
      assign mask[gi]   = (ID_W'(gi) >= ptr);
      assign onehot[gi] = any && (id == ID_W'(gi));
    end
  endgenerate

  assign masked = req & mask;
  assign any    = |req;

  always_comb begin
    sel = (|masked) ? masked : req;
    id  = '0;
    // Scan downwards so the lowest set bit of sel is the one that sticks.
    for (int i = N - 1; i >= 0; i--) begin
      if (sel[i]) begin
        id = ID_W'(i);
      end
    end
  end

endmodule

// File: rtl/rate_est_arbiter.sv
// Shares one CABAC sign-bit-cost engine among NUM_REQ RDOQ lanes.
//   clk, rst_n         : clock, asynchronous active-low reset
//   req, req_level     : per-lane request and |coeff| (lane i at [i*LVL_W +: LVL_W])
//   gnt                : one-hot, only during the response cycle
//   rsp_valid/id/cost/tmo : one-cycle response; cost is Q15 (32768 = 1 bit)
//   eng_start          : one-cycle start pulse to the cost engine
//   eng_done, eng_cost : engine completion and its cost
//   busy               : arbiter is not idle
// Zero-level coefficients have no sign bit, so they are answered with cost 0
// without touching the engine. A stalled engine is abandoned after TIMEOUT
// wait cycles and the lane receives a saturated cost so RDOQ rejects it.
module rate_est_arbiter
  import rdoq_rate_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int LVL_W   = 16,
  parameter int COST_W  = 32,
  parameter int TIMEOUT = 15
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [NUM_REQ-1:0]           req,
  input  logic [NUM_REQ*LVL_W-1:0]     req_level,
  output logic [NUM_REQ-1:0]           gnt,
  output logic                         rsp_valid,
  output logic [id_width(NUM_REQ)-1:0] rsp_id,
  output logic [COST_W-1:0]            rsp_cost,
  output logic                         rsp_tmo,
  output logic                         eng_start,
  input  logic                         eng_done,
  input  logic [COST_W-1:0]            eng_cost,
  output logic                         busy
);

  localparam int ID_W  = id_width(NUM_REQ);
  localparam int CNT_W = $clog2(TIMEOUT + 1);

  arb_state_t        state_reg, state_next;
  logic [ID_W-1:0]   ptr_reg, ptr_next;
  logic [ID_W-1:0]   id_reg, id_next;
  logic [COST_W-1:0] cost_reg, cost_next;
  logic              tmo_reg, tmo_next;
  logic [CNT_W-1:0]  cnt_reg, cnt_next;
  logic [CNT_W-1:0]  cnt_inc;

  logic [LVL_W-1:0]   level_arr [NUM_REQ];
  logic [NUM_REQ-1:0] pick_onehot;
  logic [ID_W-1:0]    pick_id;
  logic               pick_any;
  logic [LVL_W-1:0]   pick_level;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_REQ; gi++) begin : g_lane
      assign level_arr[gi] = req_level[gi*LVL_W +: LVL_W];
      assign gnt[gi]       = (state_reg == RESP) && (id_reg == ID_W'(gi));
    end
  endgenerate

  rr_pick #(
    .N    (NUM_REQ),
    .ID_W (ID_W)
  ) u_pick (
    .req    (req),
    .ptr    (ptr_reg),
    .onehot (pick_onehot),
    .id     (pick_id),
    .any    (pick_any)
  );

  // Only the index is needed; the one-hot form is kept for observability.
  logic pick_onehot_any;
  assign pick_onehot_any = |pick_onehot;

  assign pick_level = level_arr[pick_id];
  assign cnt_inc    = cnt_reg + 1'b1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      ptr_reg   <= '0;
      id_reg    <= '0;
      cost_reg  <= '0;
      tmo_reg   <= 1'b0;
      cnt_reg   <= '0;
    end else begin
      state_reg <= state_next;
      ptr_reg   <= ptr_next;
      id_reg    <= id_next;
      cost_reg  <= cost_next;
      tmo_reg   <= tmo_next;
      cnt_reg   <= cnt_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    ptr_next   = ptr_reg;
    id_next    = id_reg;
    cost_next  = cost_reg;
    tmo_next   = tmo_reg;
    cnt_next   = cnt_reg;

    eng_start  = 1'b0;
    rsp_valid  = 1'b0;
    rsp_id     = '0;
    rsp_cost   = '0;
    rsp_tmo    = 1'b0;
    busy       = (state_reg != IDLE);

    case (state_reg)
      IDLE: begin
        if (pick_any && pick_onehot_any) begin
          id_next  = pick_id;
          tmo_next = 1'b0;
          if (pick_level == '0) begin
            cost_next  = '0;
            state_next = RESP;
          end else begin
            state_next = ISSUE;
          end
        end
      end

      ISSUE: begin
        eng_start  = 1'b1;
        cnt_next   = '0;
        state_next = WAIT;
      end

      WAIT: begin
        // A done arriving in the timeout cycle still wins: the real cost is better
        // than a forced rejection.
        if (eng_done) begin
          cost_next  = eng_cost;
          tmo_next   = 1'b0;
          state_next = RESP;
        end else begin
          cnt_next = cnt_inc;
          if (cnt_inc == CNT_W'(TIMEOUT)) begin
            cost_next  = COST_MAX[COST_W-1:0];
            tmo_next   = 1'b1;
            state_next = RESP;
          end
        end
      end

      RESP: begin
        rsp_valid  = 1'b1;
        rsp_id     = id_reg;
        rsp_cost   = cost_reg;
        rsp_tmo    = tmo_reg;
        ptr_next   = (id_reg == ID_W'(NUM_REQ - 1)) ? '0 : id_reg + 1'b1;
        state_next = IDLE;
      end

      default: begin
        state_next = IDLE;
      end
    endcase
  end

endmodule
